// File: rtl/multicycle_muldiv.sv
// Iterative multiply/divide unit with its HI/LO register pair.
// Shift-add multiply or restoring divide, one step per clock, sign-fixed at the end.
module multicycle_muldiv #(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic             dz,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX, S_DONE} state_t;

  state_t               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 is_div_q, is_div_d;
  logic                 sign_a_q, sign_a_d;
  logic                 sign_b_q, sign_b_d;
  logic                 bz_q, bz_d;
  logic                 dz_q, dz_d;
  logic [WIDTH-1:0]     opnd_q, opnd_d;
  logic [WIDTH-1:0]     rem_q, rem_d;
  logic [2*WIDTH-1:0]   acc_q, acc_d;
  logic [WIDTH-1:0]     hi_q, hi_d;
  logic [WIDTH-1:0]     lo_q, lo_d;

  logic                 idle_or_done, accept, last_iter;
  logic                 sa_in, sb_in;
  logic [WIDTH-1:0]     abs_a, abs_b;
  logic [WIDTH:0]       mul_sum;
  logic [WIDTH:0]       div_shift;
  logic                 div_ge;
  logic [WIDTH-1:0]     div_diff;
  logic [2*WIDTH-1:0]   prod_fix;
  logic [WIDTH-1:0]     quo_fix, rem_fix;

  assign idle_or_done = (state_q == S_IDLE) || (state_q == S_DONE);
  assign accept       = idle_or_done && start;
  assign last_iter    = (cnt_q == CNT_W'(WIDTH - 1));

  // Signed ops work on magnitudes; unsigned ops carry zero sign bits so no fix-up happens.
  assign sa_in = op[0] & a[WIDTH-1];
  assign sb_in = op[0] & b[WIDTH-1];
  assign abs_a = sa_in ? -a : a;
  assign abs_b = sb_in ? -b : b;

  // Multiply: acc = {partial product, remaining multiplier bits}, shifted right each step.
  assign mul_sum = {1'b0, acc_q[2*WIDTH-1:WIDTH]}
                 + {1'b0, (acc_q[0] ? opnd_q : {WIDTH{1'b0}})};

  // Divide: acc[WIDTH-1:0] shifts the dividend out MSB-first while quotient bits shift in.
  assign div_shift = {rem_q, acc_q[WIDTH-1]};
  assign div_ge    = div_shift >= {1'b0, opnd_q};
  assign div_diff  = div_shift[WIDTH-1:0] - opnd_q;

  assign prod_fix = (sign_a_q ^ sign_b_q) ? -acc_q : acc_q;
  assign quo_fix  = (sign_a_q ^ sign_b_q) ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
  assign rem_fix  = sign_a_q ? -rem_q : rem_q;

  // NOTE: every signal driven in always_comb gets a default first, so no latch is inferred.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start) state_d = S_CALC;
      S_CALC:  if (last_iter) state_d = S_FIX;
      S_FIX:   state_d = S_DONE;
      S_DONE:  state_d = start ? S_CALC : S_IDLE;
      default: state_d = S_IDLE;
    endcase
    busy = (state_q == S_CALC) || (state_q == S_FIX);
    done = (state_q == S_DONE);
  end

  always_comb begin
    cnt_d    = cnt_q;
    is_div_d = is_div_q;
    sign_a_d = sign_a_q;
    sign_b_d = sign_b_q;
    bz_d     = bz_q;
    dz_d     = dz_q;
    opnd_d   = opnd_q;
    rem_d    = rem_q;
    acc_d    = acc_q;
    hi_d     = hi_q;
    lo_d     = lo_q;

    if (accept) begin
      is_div_d = op[1];
      sign_a_d = sa_in;
      sign_b_d = sb_in;
      bz_d     = (b == '0);
      dz_d     = 1'b0;
      cnt_d    = '0;
      rem_d    = '0;
      opnd_d   = op[1] ? abs_b : abs_a;
      acc_d    = {{WIDTH{1'b0}}, (op[1] ? abs_a : abs_b)};
    end else if (idle_or_done) begin
      if (hi_we) hi_d = wdata;
      if (lo_we) lo_d = wdata;
    end

    if (state_q == S_CALC) begin
      cnt_d = cnt_q + 1'b1;
      if (is_div_q) begin
        rem_d = div_ge ? div_diff : div_shift[WIDTH-1:0];
        acc_d = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-2:0], div_ge};
      end else begin
        acc_d = {mul_sum, acc_q[WIDTH-1:1]};
      end
    end

    // A zero divisor leaves rem = |a|, so rem_fix already restores the original a.
    if (state_q == S_FIX) begin
      if (is_div_q) begin
        hi_d = rem_fix;
        lo_d = bz_q ? {WIDTH{1'b1}} : quo_fix;
        dz_d = bz_q;
      end else begin
        hi_d = prod_fix[2*WIDTH-1:WIDTH];
        lo_d = prod_fix[WIDTH-1:0];
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      is_div_q <= 1'b0;
      sign_a_q <= 1'b0;
      sign_b_q <= 1'b0;
      bz_q     <= 1'b0;
      dz_q     <= 1'b0;
      opnd_q   <= '0;
      rem_q    <= '0;
      acc_q    <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      is_div_q <= is_div_d;
      sign_a_q <= sign_a_d;
      sign_b_q <= sign_b_d;
      bz_q     <= bz_d;
      dz_q     <= dz_d;
      opnd_q   <= opnd_d;
      rem_q    <= rem_d;
      acc_q    <= acc_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
    end
  end

  assign dz = dz_q;
  assign hi = hi_q;
  assign lo = lo_q;

endmodule

// File: tb/tb_multicycle_muldiv.sv
// Self-checking bench for multicycle_muldiv (WIDTH=32): scoreboard of expected
// HI/LO/dz results, latency, busy, stability, MTHI/MTLO and async reset checks.
module tb_multicycle_muldiv;

  localparam int W = 32;

  logic          CLK = 1'b0;
  logic          RST = 1'b1;
  logic          start = 1'b0;
  logic [1:0]    op = 2'b00;
  logic [W-1:0]  a = '0;
  logic [W-1:0]  b = '0;
  logic          hi_we = 1'b0;
  logic          lo_we = 1'b0;
  logic [W-1:0]  wdata = '0;
  logic          busy, done, dz;
  logic [W-1:0]  hi, lo;

  typedef struct {
    int           idx;
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic         dz;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   op_idx   = 0;

  localparam logic [1:0] MULTU = 2'b00, MULT = 2'b01, DIVU = 2'b10, DIV = 2'b11;

  multicycle_muldiv #(.WIDTH(W)) dut (
    .CLK(CLK), .RST(RST), .start(start), .op(op), .a(a), .b(b),
    .hi_we(hi_we), .lo_we(lo_we), .wdata(wdata),
    .busy(busy), .done(done), .dz(dz), .hi(hi), .lo(lo)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Scoreboard side: every done pulse must match the oldest pending expectation.
  always @(negedge CLK) begin
    if (!RST && done) begin
      if (sb.size() == 0) begin
        check("unexpected_done", 64'd1, 64'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check($sformatf("op%0d_hi", e.idx), hi, e.hi);
        check($sformatf("op%0d_lo", e.idx), lo, e.lo);
        check($sformatf("op%0d_dz", e.idx), dz, e.dz);
      end
    end
  end

  // mode 0: plain; 1: disturb inputs mid-CALC; 2: assert hi_we/lo_we together with start.
  task automatic run_op(input logic [1:0] o, input logic [W-1:0] aa, input logic [W-1:0] bb,
                        input logic [W-1:0] eh, input logic [W-1:0] el, input logic edz,
                        input int mode);
    exp_t         e;
    logic [W-1:0] hi0, lo0;
    int           n;
    bit           busy_ok, stable_ok;
    int           id;
    id = op_idx;
    e.idx = op_idx; e.hi = eh; e.lo = el; e.dz = edz;
    op_idx++;
    sb.push_back(e);
    hi0 = hi; lo0 = lo;
    start = 1'b1; op = o; a = aa; b = bb;
    if (mode == 2) begin hi_we = 1'b1; lo_we = 1'b1; wdata = 32'hCAFE_F00D; end
    @(posedge CLK); #1;
    start = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
    busy_ok = 1'b1; stable_ok = 1'b1; n = 0;
    for (int c = 1; c <= 40; c++) begin
      @(negedge CLK);
      if (c == 1) check($sformatf("op%0d_dz_clear", id), dz, 1'b0);
      if (done) begin n = c; break; end
      if (!busy) busy_ok = 1'b0;
      if (hi !== hi0 || lo !== lo0) stable_ok = 1'b0;
      if (mode == 1 && c == 10) begin
        start = 1'b1; op = DIVU; a = 32'd8; b = 32'd2;
        hi_we = 1'b1; lo_we = 1'b1; wdata = 32'h0000_DEAD;
      end
      if (mode == 1 && c == 11) begin start = 1'b0; hi_we = 1'b0; lo_we = 1'b0; end
    end
    check($sformatf("op%0d_latency", id), n, 34);
    check($sformatf("op%0d_busy_run", id), busy_ok, 1'b1);
    check($sformatf("op%0d_hilo_stable", id), stable_ok, 1'b1);
    check($sformatf("op%0d_busy_at_done", id), busy, 1'b0);
  endtask

  task automatic expect_quiet(input int cycles, input string tag);
    int cnt;
    cnt = 0;
    repeat (cycles) begin
      @(negedge CLK);
      if (done) cnt++;
    end
    check(tag, cnt, 0);
  endtask

  initial begin
    repeat (2) @(negedge CLK);
    RST = 1'b0;
    check("rst_hi", hi, 0);
    check("rst_lo", lo, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_dz", dz, 0);
    @(negedge CLK);

    run_op(MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0, 0);
    run_op(MULT,  32'hFFFF_FFF9, 32'd3,         32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0, 0);
    run_op(MULT,  32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, 1'b0, 0);
    run_op(DIVU,  32'd100,       32'd7,         32'd2,         32'd14,        1'b0, 0);
    run_op(DIV,   32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, 0);
    run_op(DIV,   32'd7,         32'hFFFF_FFFE, 32'd1,         32'hFFFF_FFFD, 1'b0, 2);
    run_op(DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         32'h8000_0000, 1'b0, 0);
    run_op(DIV,   32'hFFFF_FFF7, 32'd0,         32'hFFFF_FFF7, 32'hFFFF_FFFF, 1'b1, 0);
    run_op(DIVU,  32'd5,         32'd0,         32'd5,         32'hFFFF_FFFF, 1'b1, 0);
    @(negedge CLK);
    check("dz_hold", dz, 1'b1);
    run_op(MULTU, 32'd3,         32'd5,         32'd0,         32'd15,        1'b0, 0);

    // MTLO / MTHI from idle.
    @(negedge CLK);
    lo_we = 1'b1; wdata = 32'h0000_1234;
    @(negedge CLK);
    lo_we = 1'b0;
    check("mtlo_lo", lo, 32'h0000_1234);
    check("mtlo_hi_kept", hi, 32'd0);
    hi_we = 1'b1; lo_we = 1'b1; wdata = 32'h0BAD_BEEF;
    @(negedge CLK);
    hi_we = 1'b0; lo_we = 1'b0;
    check("mt_both_hi", hi, 32'h0BAD_BEEF);
    check("mt_both_lo", lo, 32'h0BAD_BEEF);

    run_op(DIVU, 32'd9, 32'd3, 32'd0, 32'd3, 1'b0, 1);
    expect_quiet(40, "no_extra_done");

    hi_we = 1'b1; wdata = 32'h0000_BEEF;
    @(negedge CLK);
    hi_we = 1'b0;
    check("mthi_hi", hi, 32'h0000_BEEF);

    // Async reset in CALC cycle 10 of a MULTU.
    start = 1'b1; op = MULTU; a = 32'h0001_2345; b = 32'h0000_0777;
    @(posedge CLK); #1;
    start = 1'b0;
    repeat (10) @(negedge CLK);
    check("pre_rst_busy", busy, 1'b1);
    #2 RST = 1'b1;
    #1;
    check("async_rst_hi", hi, 0);
    check("async_rst_lo", lo, 0);
    check("async_rst_busy", busy, 0);
    check("async_rst_done", done, 0);
    check("async_rst_dz", dz, 0);
    @(negedge CLK);
    @(negedge CLK);
    RST = 1'b0;
    expect_quiet(40, "no_done_after_rst");

    run_op(MULTU, 32'd6, 32'd7, 32'd0, 32'd42, 1'b0, 0);
    @(negedge CLK);
    check("sb_empty", sb.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
